// File: rtl/uart_rx_pkg.sv
// Shared types for the multi-channel UART receive capture engine.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     ferr;
        logic                     perr;
    } frame_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_chan.sv
// One receive lane: 2-flop synchronizer, mid-bit sampling FSM and a one-frame hold register.
// UART_RX_PARITY_EN adds the parity bit slot and the ODD parameter.
module uart_rx_chan
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD          = 1'b0
`endif
) (
    input  logic   HCLK,
    input  logic   HRESET,
    input  logic   rx,
    input  logic   grant,
    output logic   hold_full,
    output frame_t hold_frame,
    output logic   drop
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_p0, rx_p1, rx_p2;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr_r, perr_n;
    logic                 done, done_ferr;
    frame_t               frame_n;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            {rx_p2, rx_p1, rx_p0} <= 3'b111;
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            {rx_p2, rx_p1, rx_p0} <= {rx_p1, rx_p0, rx};
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
        end
    end

    always_ff @(posedge HCLK) begin
        shreg  <= shreg_n;
        perr_r <= perr_n;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        perr_n    = perr_r;
        done      = 1'b0;
        done_ferr = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (rx_p2 && !rx_p1) state_n = ST_START;
            end
            ST_START: if (cnt == HALF_M1) begin
                // A start bit that is high again at mid-bit was a glitch.
                cnt_n   = '0;
                bit_n   = '0;
                perr_n  = 1'b0;
                state_n = rx_p1 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt == FULL_M1) begin
                cnt_n   = '0;
                shreg_n = {rx_p1, shreg[DATA_BITS-1:1]};
                bit_n   = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_cnt == LAST_BIT) state_n = ST_PARITY;
`else
                if (bit_cnt == LAST_BIT) state_n = ST_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (cnt == FULL_M1) begin
                cnt_n   = '0;
                perr_n  = rx_p1 ^ (^shreg) ^ ODD;
                state_n = ST_STOP;
            end
`endif
            ST_STOP: if (cnt == FULL_M1) begin
                cnt_n     = '0;
                done      = 1'b1;
                done_ferr = !rx_p1;
                state_n   = rx_p1 ? ST_IDLE : ST_BRK;
            end
            ST_BRK: begin
                cnt_n = '0;
                if (rx_p1) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_n                      = '0;
        frame_n.data[DATA_BITS-1:0]  = shreg;
        frame_n.ferr                 = done_ferr;
        frame_n.perr                 = perr_r;
    end

    // A hold slot being drained this cycle can take the new frame.
    assign drop = done && hold_full && !grant;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)                              hold_full <= 1'b0;
        else if (done && (!hold_full || grant))  hold_full <= 1'b1;
        else if (grant)                          hold_full <= 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (done && (!hold_full || grant)) hold_frame <= frame_n;
    end

endmodule

// File: rtl/uart_rx_capture.sv
// Multi-channel UART capture: per-channel receivers, round-robin arbiter, shared tagged FIFO.
// Define UART_RX_PARITY_EN to receive a parity bit per frame and report mismatches on m_perr.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD          = 1'b0
`endif
) (
    input  logic                                          HCLK,
    input  logic                                          HRESET,
    input  logic [CHANNELS-1:0]                           rx,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_BITS-1:0]                          m_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] m_chan,
    output logic                                          m_ferr,
    output logic                                          m_perr,
    output logic [CHANNELS-1:0]                           ovf,
    input  logic [CHANNELS-1:0]                           ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]                   fifo_level
);

    localparam int CHW = chan_w(CHANNELS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LVW = AW + 1;

    logic [CHANNELS-1:0] hold_full, grant, drop;
    frame_t              hold_frame [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        uart_rx_chan #(
            .DATA_BITS    (DATA_BITS),
            .CLKS_PER_BIT (CLKS_PER_BIT)
`ifdef UART_RX_PARITY_EN
            ,
            .ODD          (ODD)
`endif
        ) u_chan (
            .HCLK       (HCLK),
            .HRESET     (HRESET),
            .rx         (rx[g]),
            .grant      (grant[g]),
            .hold_full  (hold_full[g]),
            .hold_frame (hold_frame[g]),
            .drop       (drop[g])
        );
    end

    logic [CHW-1:0] rr_ptr, win;
    logic           win_vld, can_push, push, pop;
    int             arb_idx;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]  rd_idx;
    logic           fifo_full, fifo_empty;
    frame_t         mem_frame [FIFO_DEPTH];
    logic [CHW-1:0] mem_chan  [FIFO_DEPTH];

    // Scan downwards so the lowest offset from rr_ptr is the last, winning match.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        arb_idx = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= CHANNELS) arb_idx = arb_idx - CHANNELS;
            if (hold_full[CHW'(arb_idx)]) begin
                win     = CHW'(arb_idx);
                win_vld = 1'b1;
            end
        end
    end

    assign pop      = m_valid && m_ready;
    assign can_push = !fifo_full || pop;
    assign push     = win_vld && can_push;

    always_comb begin
        grant = '0;
        if (push) grant[win] = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)    rr_ptr <= '0;
        else if (push) rr_ptr <= (int'(win) == CHANNELS - 1) ? '0 : win + 1'b1;
    end

    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_level = LVW'(wr_ptr - rd_ptr);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_frame[wr_ptr[AW-1:0]] <= hold_frame[win];
            mem_chan[wr_ptr[AW-1:0]]  <= win;
        end
    end

    // Head fields are forced to zero while empty so reset shows all-zero outputs.
    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? mem_frame[rd_idx].data[DATA_BITS-1:0] : '0;
    assign m_chan  = m_valid ? mem_chan[rd_idx] : '0;
    assign m_ferr  = m_valid && mem_frame[rd_idx].ferr;
`ifdef UART_RX_PARITY_EN
    assign m_perr  = m_valid && mem_frame[rd_idx].perr;
`else
    assign m_perr  = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) ovf <= '0;
        else        ovf <= (ovf & ~ovf_clr) | drop;
    end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed plus randomized bench for uart_rx_capture against a frame-level reference queue.
module tb_uart_rx_capture;

    localparam int CH  = 4;
    localparam int DB  = 8;
    localparam int CPB = 16;
    localparam int FD  = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [CH-1:0] rx = '1;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DB-1:0] m_data;
    logic [1:0]    m_chan;
    logic          m_ferr, m_perr;
    logic [CH-1:0] ovf;
    logic [CH-1:0] ovf_clr = '0;
    logic [2:0]    fifo_level;

    always #5 HCLK = ~HCLK;

    uart_rx_capture #(
        .CHANNELS(CH), .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .rx(rx), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_chan(m_chan), .m_ferr(m_ferr), .m_perr(m_perr),
        .ovf(ovf), .ovf_clr(ovf_clr), .fifo_level(fifo_level)
    );

    typedef struct {
        int chan;
        int data;
        int ferr;
        int perr;
    } item_t;

    item_t got[$];
    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    always @(negedge HCLK) begin
        if (!HRESET && m_valid && m_ready)
            got.push_back('{int'(m_chan), int'(m_data), int'(m_ferr), int'(m_perr)});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] mask, input logic [3:0] v);
        for (int c = 0; c < CH; c++) if (mask[c]) rx[c] = v[c];
        repeat (CPB) tick();
    endtask

    // Serial frame on every channel in mask: start, LSB-first data, optional parity, stop.
    task automatic send(input logic [3:0] mask, input logic [31:0] d, input logic [3:0] par,
                        input int stop_low);
        logic [3:0] v;
        drive(mask, 4'b0000);
        for (int b = 0; b < DB; b++) begin
            for (int c = 0; c < CH; c++) v[c] = d[c*8+b];
            drive(mask, v);
        end
        if (PAR_EN) drive(mask, par);
        if (stop_low > 0) begin
            for (int k = 0; k < stop_low; k++) drive(mask, 4'b0000);
        end else begin
            drive(mask, 4'b1111);
        end
        drive(mask, 4'b1111);
        drive(mask, 4'b1111);
    endtask

    function automatic void exp_add(input int ch, input int data, input int stop_low, input int par);
        item_t it;
        it.chan = ch;
        it.data = data & 255;
        it.ferr = (stop_low > 0) ? 1 : 0;
        it.perr = PAR_EN ? ((par ^ $countones(data & 255)) & 1) : 0;
        exp_q.push_back(it);
    endfunction

    task automatic wait_got(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 4000) begin
            tick();
            n++;
        end
        repeat (2 * CPB) tick();
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_chan"}, got[i].chan, exp_q[i].chan);
            check({tag, "_data"}, got[i].data, exp_q[i].data);
            check({tag, "_ferr"}, got[i].ferr, exp_q[i].ferr);
            check({tag, "_perr"}, got[i].perr, exp_q[i].perr);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        rx     = '1;
        repeat (2) tick();
        HRESET = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int ch, d, sl, p;

        repeat (3) tick();
        check("rst_valid", m_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", m_data, 0);
        check("rst_chan", m_chan, 0);
        check("rst_ferr", m_ferr, 0);
        check("rst_perr", m_perr, 0);
        HRESET = 1'b0;
        repeat (4) tick();

        // single frame, consumer always ready
        m_ready = 1'b1;
        send(4'b0001, 32'h0000_0055, 4'b0000, 0);
        exp_add(0, 'h55, 0, 0);
        wait_got("t1");
        check("t1_level", fifo_level, 0);

        // four simultaneous frames into a stalled FIFO
        do_reset();
        m_ready = 1'b0;
        send(4'b1111, 32'h4141_4141, 4'b0000, 0);
        for (int n = 0; n < 500 && fifo_level != 3'd4; n++) tick();
        check("t2_level", fifo_level, 4);
        check("t2_valid", m_valid, 1);
        check("t2_head_chan", m_chan, 0);
        check("t2_head_data", m_data, 'h41);

        // full FIFO: first frame parks in hold, second is dropped
        send(4'b0100, 32'h0010_0000, 4'b0000, 0);
        check("t3_level", fifo_level, 4);
        check("t3_ovf_before", ovf, 0);
        send(4'b0100, 32'h0020_0000, 4'b0000, 0);
        check("t3_ovf_set", ovf, 4'b0100);
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        check("t3_ovf_clr", ovf, 0);
        for (int c = 0; c < CH; c++) exp_add(c, 'h41, 0, 0);
        exp_add(2, 'h10, 0, 0);
        m_ready = 1'b1;
        wait_got("t3");
        check("t3_ovf_after", ovf, 0);

        // stop bit held low for three bit times, then a clean frame
        send(4'b0010, 32'h0000_A300, 4'b0000, 3);
        exp_add(1, 'hA3, 3, 0);
        wait_got("t4");
        send(4'b0010, 32'h0000_3C00, 4'b0000, 0);
        exp_add(1, 'h3C, 0, 0);
        wait_got("t4b");

        // short low glitch is ignored
        rx[3] = 1'b0;
        repeat (4) tick();
        rx[3] = 1'b1;
        repeat (3 * CPB) tick();
        check("t5_glitch_count", got.size(), 0);
        check("t5_glitch_level", fifo_level, 0);
        send(4'b1000, 32'h5A00_0000, 4'b0000, 0);
        exp_add(3, 'h5A, 0, 0);
        wait_got("t5");

        // reset in the middle of the data bits
        drive(4'b0001, 4'b0000);
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0000);
        drive(4'b0001, 4'b0001);
        HRESET = 1'b1;
        rx     = '1;
        repeat (3) tick();
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_level", fifo_level, 0);
        HRESET = 1'b0;
        repeat (15 * CPB) tick();
        check("t5_post_level", fifo_level, 0);
        check("t5_post_valid", m_valid, 0);
        check("t5_post_count", got.size(), 0);

        // parity slot: 0x07 has odd weight, so an even-parity bit of 0 mismatches
        send(4'b0001, 32'h0000_0007, 4'b0000, 0);
        exp_add(0, 'h07, 0, 0);
        send(4'b0001, 32'h0000_0007, 4'b0001, 0);
        exp_add(0, 'h07, 0, 1);
        wait_got("t6");

        // randomized single-channel frames
        for (int r = 0; r < 12; r++) begin
            ch = int'($urandom_range(0, CH - 1));
            d  = int'($urandom_range(0, 255));
            sl = ($urandom_range(0, 3) == 0) ? 1 : 0;
            p  = int'($urandom_range(0, 1));
            send(4'(1 << ch), 32'(d) << (8 * ch), 4'(p << ch), sl);
            exp_add(ch, d, sl, p);
        end
        wait_got("rand");
        check("end_ovf", ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
